// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr} with valid/ready on both sides.
// Optional same-cycle forwarding when empty is enabled by defining IFQ_BYPASS_EN.
module if_id_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [6:0]               out_opcode,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic empty;
  logic bypass_take;
  logic push;
  logic pop;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q < DEPTH_C);
  assign count    = count_q;

`ifdef IFQ_BYPASS_EN
  assign bypass_take = empty && in_valid && !flush && out_ready;
`else
  assign bypass_take = 1'b0;
`endif

  // A forwarded-and-consumed entry never touches the storage or the pointers.
  assign push = in_valid && in_ready && !flush && !bypass_take;
  assign pop  = !empty && out_ready && !flush;

  always_comb begin
    out_valid = !empty && !flush;
    out_pc    = empty ? '0 : pc_mem_q[rptr_q];
    out_instr = empty ? NOP_INSTR : instr_mem_q[rptr_q];
`ifdef IFQ_BYPASS_EN
    if (empty && in_valid && !flush) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end
`endif
  end

  assign out_opcode = out_instr[6:0];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= NOP_INSTR;
      end
    end else if (push) begin
      pc_mem_q[wptr_q]    <= in_pc;
      instr_mem_q[wptr_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a queue-based reference model updated per clock edge,
// a negedge monitor comparing every DUT output, plus directed scenarios and random traffic.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_pc = '0;
  logic [31:0]   in_instr = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [6:0]    out_opcode;
  logic [CW-1:0] count;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_opcode(out_opcode), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];     // expected contents, head at index 0
  logic [31:0] seen[$];   // PCs the DUT handed to decode
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: accept/consume decided from queue occupancy and the rules of the handshake.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else begin
      bit do_push, do_pop;
      ent_t e;
      do_push = in_valid && (mq.size() < DEPTH) && !flush;
      do_pop  = out_ready && !flush && (mq.size() != 0);
      if (BYP && mq.size() == 0 && in_valid && !flush && out_ready) do_push = 1'b0;
      if (flush) mq.delete();
      else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          e.pc = in_pc;
          e.instr = in_instr;
          mq.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      logic        ev;
      logic [31:0] epc, ein;
      ev  = (mq.size() != 0) && !flush;
      epc = '0;
      ein = NOP;
      if (mq.size() != 0) begin
        epc = mq[0].pc;
        ein = mq[0].instr;
      end
      if (BYP && mq.size() == 0 && in_valid && !flush) begin
        ev  = 1'b1;
        epc = in_pc;
        ein = in_instr;
      end
      chk("mon_out_valid", 32'(out_valid), 32'(ev));
      chk("mon_count", 32'(count), mq.size());
      chk("mon_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("mon_out_pc", out_pc, epc);
      chk("mon_out_instr", out_instr, ein);
      chk("mon_out_opcode", 32'(out_opcode), 32'(ein[6:0]));
      if (out_valid && out_ready) seen.push_back(out_pc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic r);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = {pc[24:0], 7'h33};
    out_ready = r;
  endtask

  task automatic drain();
    int n = 0;
    drive(1'b0, '0, 1'b1);
    while (mq.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk("drain_bound", 32'(mq.size()), 0);
  endtask

  task automatic check_seen(input string name, input logic [31:0] exp[]);
    chk({name, "_len"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++)
      chk(name, seen[i], exp[i]);
  endtask

  initial begin
    logic [31:0] exp[];
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_instr", out_instr, NOP);
    chk("rst_out_opcode", 32'(out_opcode), 32'h13);
    chk("rst_out_pc", out_pc, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    cyc();

    // Fill to full, offer a fifth, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0);
      cyc();
    end
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    drive(1'b1, 32'h10, 1'b0);
    cyc();
    chk("full_refuse_count", 32'(count), 4);
    seen.delete();
    drive(1'b0, '0, 1'b1);
    repeat (4) cyc();
    chk("drain_count", 32'(count), 0);
    exp = '{32'h00, 32'h04, 32'h08, 32'h0C};
    check_seen("fill_order", exp);

    // Ten pushes across the pointer wrap with occupancy held at 1..3.
    seen.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i * 4), i >= 2);
      cyc();
    end
    drain();
    exp = new[10];
    for (int i = 0; i < 10; i++) exp[i] = 32'(i * 4);
    check_seen("wrap_order", exp);

    // Simultaneous push and pop at count 2.
    drive(1'b1, 32'h38, 1'b0); cyc();
    drive(1'b1, 32'h3C, 1'b0); cyc();
    drive(1'b1, 32'h40, 1'b1); cyc();
    chk("pp_count", 32'(count), 2);
    chk("pp_head", out_pc, 32'h3C);
    drain();

    // Flush with three entries while fetch offers 0x100.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h50 + 32'(i * 4), 1'b0);
      cyc();
    end
    seen.delete();
    drive(1'b1, 32'h100, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_out_valid", 32'(out_valid), 0);
    cyc();
    flush = 1'b0;
    chk("flush_count", 32'(count), 0);
    drive(1'b1, 32'h200, 1'b0);
    cyc();
    chk("post_flush_head", out_pc, 32'h200);
    chk("post_flush_valid", 32'(out_valid), 1);
    drain();
    exp = '{32'h200};
    check_seen("flush_seen", exp);

    // Empty-queue latency, with or without forwarding.
    in_valid = 1'b1; in_pc = 32'h80; in_instr = 32'h0000_0063; out_ready = 1'b1;
    #1;
    chk("byp_valid_now", 32'(out_valid), 32'(BYP));
    if (BYP) begin
      chk("byp_pc_now", out_pc, 32'h80);
      chk("byp_opcode_now", 32'(out_opcode), 32'h63);
    end
    cyc();
    in_valid = 1'b0;
    #1;
    chk("byp_valid_next", 32'(out_valid), 32'(!BYP));
    chk("byp_count_next", 32'(count), 32'(!BYP));
    drain();

    // Asynchronous reset mid-cycle with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), 1'b0);
      cyc();
    end
    drive(1'b0, '0, 1'b0);
    #1;
    chk("pre_areset_count", 32'(count), 3);
    reset = 1'b1;
    #1;
    chk("areset_out_valid", 32'(out_valid), 0);
    chk("areset_count", 32'(count), 0);
    chk("areset_out_instr", out_instr, NOP);
    chk("areset_in_ready", 32'(in_ready), 1);
    chk("areset_opcode", 32'(out_opcode), 32'h13);
    #1;
    reset = 1'b0;
    cyc();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      in_instr  = $urandom;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 16) == 0;
      cyc();
    end
    flush = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and decode. Captures each fetched {pc, instruction} pair with a valid/ready handshake and buffers up to DEPTH entries so decode stalls do not freeze the program counter. It presents the head entry, plus its opcode field, to decode and to the PC-select control. A flush discards all buffered entries on a taken branch or jump.

## Interface
- DEPTH, 4, number of queue entries; power of two, 2..16
- NOP_INSTR, 32'h0000_0013, value driven on out_instr while the queue is empty (addi x0,x0,0)

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}
- in_ready  output  1  queue can accept an entry this cycle
- in_pc  input  32  address of fetched instruction
- in_instr  input  32  fetched instruction word
- flush  input  1  discard all entries (taken branch/jump)
- out_valid  output  1  head entry valid for decode
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  32  head entry PC
- out_instr  output  32  head entry instruction
- out_opcode  output  7  out_instr[6:0]
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer: write pointer, read pointer, occupancy counter. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push occurs when in_valid && in_ready && !flush. It writes the entry at wptr and increments wptr.
- Pop occurs when out_valid && out_ready. It increments rptr.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- in_ready = (count < DEPTH). It depends only on registered state, with no combinational path from out_ready. Push is refused when full even if a pop happens in the same cycle.
- out_valid = (count != 0) && !flush.
- out_pc and out_instr come from the entry at rptr.
- When empty, out_pc = 0 and out_instr = NOP_INSTR.
- Flush:
  - On the next edge, wptr, rptr and count return to 0.
  - Any push or pop in the flush cycle is discarded.
  - in_ready keeps its count-based value, but data offered during flush is dropped.
- Reset (asynchronous) forces:
  - count = 0, pointers = 0, all entry valid state cleared.
  - out_valid = 0, in_ready = 1, out_pc = 0, out_instr = NOP_INSTR, out_opcode = 7'h13.
- Reset asserted mid-operation clears the queue immediately, independent of clk.

## Timing
- Base latency (bypass disabled): an entry pushed at edge N is visible on out_* and out_valid after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle sustained for any occupancy between 1 and DEPTH-1.
- Full, with out_ready high: the pop completes at the edge and in_ready rises in the following cycle.
- flush to out_valid low: combinational, same cycle.
- flush to empty state: one edge.
- The first entry after a flush can be pushed in the cycle after flush.
- Paths:
  - out_opcode is combinational from out_instr.
  - out_valid is combinational from count and flush only.

## Configuration
- IFQ_BYPASS_EN defined: when count == 0 and in_valid && !flush, the input is forwarded combinationally.
  - out_valid = 1, out_pc = in_pc, out_instr = in_instr.
  - If out_ready is also high, the entry is consumed directly and not written to the queue; count stays 0. This gives zero-cycle latency when empty.
  - If out_ready is low, the entry is written normally.
- IFQ_BYPASS_EN undefined: no forwarding. There is always one cycle of latency, and the out_* timing paths start at registers.

## Test plan
- Reset: assert reset mid-stream with count = 3, with no clock edge -> out_valid = 0, count = 0, out_instr = 32'h0000_0013, in_ready = 1 immediately.
- Fill/drain: out_ready = 0, push PCs 0x00, 0x04, 0x08, 0x0C -> count = 4 and in_ready = 0. A fifth push of 0x10 is not accepted. Then out_ready = 1 -> PCs emerge in order 0x00..0x0C, with count = 0 after four cycles.
- Wrap-around: 10 pushes with pops interleaved so occupancy stays between 1 and 3 -> the order of all ten PCs 0x00..0x24 is preserved across the pointer wrap.
- Simultaneous push/pop at count = 2: push 0x40 and pop head 0x38 -> count stays 2 and the next head is 0x3C.
- Flush with count = 3 and in_valid = 1 (pc 0x100): out_valid goes low in the flush cycle and the next cycle shows count = 0. Then push 0x200 -> head becomes 0x200, and 0x100 never appears.
- Bypass: with IFQ_BYPASS_EN defined, while empty, drive in_valid = 1, in_pc = 0x80, in_instr = 32'h0000_0063, out_ready = 1 -> same cycle out_valid = 1, out_pc = 0x80, out_opcode = 7'h63, and count remains 0.
  - Without IFQ_BYPASS_EN, the same stimulus -> out_valid = 0 in that cycle and 1 in the next.
